// File: rtl/procesador_pkg.sv
// Shared loader types and defaults: state encoding, memory geometry, count-field width.
package procesador_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    BYTE   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } ld_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_ready flags the fourth byte.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] bcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
      word <= '0;
    end else if (clr) begin
      bcnt <= '0;
      word <= '0;
    end else if (en) begin
      // New bytes enter at the top so the first byte ends in bits 7:0.
      bcnt <= bcnt + 2'd1;
      word <= {din, word[31:8]};
    end
  end

  assign word_ready = en && (bcnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams a counted program image into instruction memory, then releases the PC.
// Optional trailing XOR checksum stage: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import procesador_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_we,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ld_state_e         state, nxt;
  logic [7:0]        cnt_lo;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic              word_ready;
  logic              acc_b, start_ld, asm_en, cnt_bad, last;
  logic [CNT_W-1:0]  cnt_nxt;

  assign acc_b    = rx_valid && rx_ready;
  assign start_ld = load_req && (state == IDLE || state == DONE || state == ERR);
  assign asm_en   = acc_b && (state == BYTE || state == CHK);
  assign cnt_nxt  = {rx_data, cnt_lo};
  assign cnt_bad  = (cnt_nxt == '0) || (32'(cnt_nxt) > 32'(DEPTH));
  assign last     = (32'(idx) == 32'(cnt) - 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] xacc;
  logic        ck_match;
  // Compare against the word as it will look once this fourth byte lands.
  assign ck_match = ({rx_data, word[31:8]} == xacc);
`endif

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ld),
    .en         (asm_en),
    .din        (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (load_req) nxt = CNT_LO;
      CNT_LO:          if (acc_b) nxt = CNT_HI;
      CNT_HI:          if (acc_b) nxt = cnt_bad ? ERR : BYTE;
      BYTE:            if (word_ready) nxt = WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
      WRITE:           nxt = last ? CHK : BYTE;
      CHK:             if (word_ready) nxt = ck_match ? DONE : ERR;
`else
      WRITE:           nxt = last ? DONE : BYTE;
`endif
      default:         nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    im_we    = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      CNT_LO, CNT_HI, BYTE: begin rx_ready = 1'b1; busy = 1'b1; end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:                  begin rx_ready = 1'b1; busy = 1'b1; end
`endif
      WRITE:                begin im_we = 1'b1; busy = 1'b1; end
      DONE:                 begin start = 1'b1; done = 1'b1; end
      ERR:                  error = 1'b1;
      default:              ;
    endcase
  end

  assign im_addr  = idx;
  assign im_wdata = word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lo <= '0;
      cnt    <= '0;
      idx    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xacc   <= '0;
`endif
    end else begin
      if (start_ld) begin
        idx  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        xacc <= '0;
`endif
      end
      if (acc_b && state == CNT_LO) cnt_lo <= rx_data;
      if (acc_b && state == CNT_HI) cnt    <= cnt_nxt;
      // Hold the index on the final word so it never steps past DEPTH-1.
      if (state == WRITE && !last) idx <= idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (state == WRITE) xacc <= xacc ^ word;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; checksum scenario runs when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
  import procesador_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, im_we, start, busy, done, error;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;

  int ncmp = 0;
  int nerr = 0;
  logic [39:0] wlog [$];

  prog_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_we(im_we), .start(start), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && im_we) wlog.push_back({im_addr, im_wdata});

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rx_ready_wait", {39'd0, rx_ready}, 40'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic finish_load(input logic [31:0] ck);
`ifdef PROG_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send(ck[8*i +: 8]);
`else
    @(negedge clk);
`endif
  endtask

  function automatic logic [39:0] wl(input int i);
    return (wlog.size() > i) ? wlog[i] : 40'hFF_FFFF_FFFF;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy",  {39'd0, busy},     40'd0);
    chk("rst_done",  {39'd0, done},     40'd0);
    chk("rst_error", {39'd0, error},    40'd0);
    chk("rst_start", {39'd0, start},    40'd0);
    chk("rst_we",    {39'd0, im_we},    40'd0);
    chk("rst_ready", {39'd0, rx_ready}, 40'd0);
    chk("rst_state", 40'(dut.state),    40'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Two-word load, with a stray load_req mid-word.
    wlog.delete();
    pulse_load();
    chk("s1_busy", {39'd0, busy}, 40'd1);
    send(8'h02); send(8'h00); send(8'h11);
    chk("s1_in_byte", 40'(dut.state), 40'(BYTE));
    pulse_load();
    chk("s1_ldreq_ignored", 40'(dut.state), 40'(BYTE));
    send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    finish_load(32'h99FF99BB);
    chk("s1_done",  {39'd0, done},  40'd1);
    chk("s1_start", {39'd0, start}, 40'd1);
    chk("s1_busy0", {39'd0, busy},  40'd0);
    chk("s1_nwr",   40'(wlog.size()), 40'd2);
    chk("s1_w0",    wl(0), {8'h00, 32'h44332211});
    chk("s1_w1",    wl(1), {8'h01, 32'hDDCCBBAA});

    // Reload from DONE drops start immediately.
    pulse_load();
    chk("s6_start0", {39'd0, start}, 40'd0);
    chk("s6_done0",  {39'd0, done},  40'd0);
    chk("s6_state",  40'(dut.state), 40'(CNT_LO));

    // Zero count and oversize count abort; a good load recovers.
    wlog.delete();
    send(8'h00); send(8'h00);
    chk("s2_err",    {39'd0, error}, 40'd1);
    chk("s2_start0", {39'd0, start}, 40'd0);
    chk("s2_nwr",    40'(wlog.size()), 40'd0);
    pulse_load();
    send(8'h01); send(8'h01);
    chk("s2_err_257", {39'd0, error}, 40'd1);
    pulse_load();
    chk("s2_err_clr", {39'd0, error}, 40'd0);
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    finish_load(32'h12345678);
    chk("s2_done", {39'd0, done}, 40'd1);
    chk("s2_nwr1", 40'(wlog.size()), 40'd1);
    chk("s2_w0",   wl(0), {8'h00, 32'h12345678});

    // Gappy rx_valid with a long stall holding a partial word.
    wlog.delete();
    pulse_load();
    send(8'h01); @(negedge clk);
    send(8'h00); @(negedge clk);
    send(8'hEF); @(negedge clk);
    send(8'hBE);
    repeat (5) @(negedge clk);
    chk("s3_stall", 40'(dut.state), 40'(BYTE));
    send(8'hAD); @(negedge clk);
    send(8'hDE);
    chk("s3_we",    {39'd0, im_we},    40'd1);
    chk("s3_ready", {39'd0, rx_ready}, 40'd0);
    chk("s3_addr",  40'(im_addr),      40'd0);
    chk("s3_data",  40'(im_wdata),     40'hDEADBEEF);
    finish_load(32'hDEADBEEF);
    chk("s3_done", {39'd0, done}, 40'd1);
    chk("s3_nwr",  40'(wlog.size()), 40'd1);

    // Asynchronous reset mid-word, then a clean load.
    wlog.delete();
    pulse_load();
    send(8'h02); send(8'h00); send(8'hAA); send(8'hBB);
    rst = 1'b0;
    #1;
    chk("s4_state", 40'(dut.state),    40'(IDLE));
    chk("s4_busy",  {39'd0, busy},     40'd0);
    chk("s4_ready", {39'd0, rx_ready}, 40'd0);
    chk("s4_we",    {39'd0, im_we},    40'd0);
    chk("s4_sdone", {37'd0, start, done, error}, 40'd0);
    chk("s4_addr",  40'(im_addr),  40'd0);
    chk("s4_data",  40'(im_wdata), 40'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_load();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    finish_load(32'h04030201);
    chk("s4_done", {39'd0, done}, 40'd1);
    chk("s4_nwr",  40'(wlog.size()), 40'd1);
    chk("s4_w0",   wl(0), {8'h00, 32'h04030201});

`ifdef PROG_LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      pulse_load();
      send(8'h02); send(8'h00);
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'h03); send(8'h00); send(8'h00); send(8'h00);
      send(pass == 0 ? 8'h02 : 8'h03); send(8'h00); send(8'h00); send(8'h00);
      chk("s5_done",  {39'd0, done},  pass == 0 ? 40'd1 : 40'd0);
      chk("s5_error", {39'd0, error}, pass == 0 ? 40'd0 : 40'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
